// File: rtl/sisc_mem_resp.sv
// Data-memory responder for the SISC multi-cycle datapath: four-phase req/ack
// handshake, programmable wait states, internal word array with range error flag.
module sisc_mem_resp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              mem_busy
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range;
    logic              access;
    logic              wr_en;
    logic [IDX_W-1:0]  idx;

    assign in_range = (32'(addr_q) < DEPTH_U);
    assign idx      = addr_q[IDX_W-1:0];
    // A request dropped on the final BUSY edge still aborts: the access needs req high.
    assign access   = (state_q == S_BUSY) && mem_req && (cnt_q == 4'd0);
    assign wr_en    = access && we_q && in_range;

    // Array and captured request carry no reset; a reset parks the FSM in IDLE,
    // which is enough to drop any in-flight store.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && mem_req) begin
            we_q    <= mem_we;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
        if (wr_en) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_req) begin
                        cnt_q   <= 4'(WAIT_CYC);
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!mem_req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        err_q <= !in_range;
                        if (!in_range) begin
                            rdata_q <= '0;
                        end else if (!we_q) begin
                            rdata_q <= mem_q[idx];
                        end
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (!mem_req) begin
                        state_q <= S_IDLE;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ack   = ack_q;
    assign mem_err   = err_q;
    assign mem_busy  = busy_q;

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Scoreboard bench for sisc_mem_resp: two instances (DEPTH=16/WAIT_CYC=2 and
// DEPTH=256/WAIT_CYC=0) driven by directed and random accesses.
module tb_sisc_mem_resp;

    typedef struct {
        int          inst;
        int          ack_cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_f;
    logic        req   [2];
    logic        we_s  [2];
    logic [7:0]  addr_s[2];
    logic [31:0] wd_s  [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];

    int   n_chk;
    int   n_fail;
    int   cyc;
    exp_t sbq[$];

    logic [31:0] mem_m   [2][256];
    bit          wr_m    [2][256];
    logic [31:0] last_rd [2];
    logic        last_err[2];
    logic        ack_prev[2];

    sisc_mem_resp #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_CYC(2)) u0 (
        .clk(clk), .rst_f(rst_f), .mem_req(req[0]), .mem_we(we_s[0]),
        .mem_addr(addr_s[0]), .mem_wdata(wd_s[0]), .mem_rdata(rdata[0]),
        .mem_ack(ack[0]), .mem_err(err[0]), .mem_busy(busy[0])
    );

    sisc_mem_resp #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) u1 (
        .clk(clk), .rst_f(rst_f), .mem_req(req[1]), .mem_we(we_s[1]),
        .mem_addr(addr_s[1]), .mem_wdata(wd_s[1]), .mem_rdata(rdata[1]),
        .mem_ack(ack[1]), .mem_err(err[1]), .mem_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth(input int k);
        return (k == 0) ? 16 : 256;
    endfunction

    function automatic int wc(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ack[k] === 1'b1 && ack_prev[k] !== 1'b1) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: inst %0d acked with no request outstanding (cycle %0d)", k, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ack_inst",    32'(k),       32'(e.inst));
                    chk("ack_latency", 32'(cyc),     32'(e.ack_cyc));
                    chk("ack_rdata",   rdata[k],     e.rdata);
                    chk("ack_err",     32'(err[k]),  32'(e.err));
                end
            end
            ack_prev[k] = ack[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int k, input bit we, input int addr,
                          input logic [31:0] wd, input bit scramble);
        exp_t e;
        bit   inr;
        bit   got;
        int   hold;
        inr       = (addr < depth(k));
        e.inst    = k;
        e.ack_cyc = cyc + wc(k) + 2;
        e.err     = !inr;
        if (!inr)    e.rdata = 32'h0;
        else if (we) e.rdata = last_rd[k];
        else         e.rdata = mem_m[k][addr];
        if (we && inr) begin
            mem_m[k][addr] = wd;
            wr_m[k][addr]  = 1'b1;
        end
        last_rd[k]  = e.rdata;
        last_err[k] = e.err;
        sbq.push_back(e);

        we_s[k]   = we;
        addr_s[k] = 8'(addr);
        wd_s[k]   = wd;
        req[k]    = 1'b1;
        tick();
        if (scramble) begin
            we_s[k]   = 1'($urandom_range(0, 1));
            addr_s[k] = 8'($urandom_range(0, 255));
            wd_s[k]   = $urandom;
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ack[k] === 1'b1) begin
                got = 1'b1;
                break;
            end
            chk("busy_wait", 32'(busy[k]), 32'd1);
            tick();
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: inst %0d got no ack, required within 40 cycles", k);
            sbq.delete();
        end
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("ack_hold", 32'(ack[k]), 32'd1);
        end
        req[k] = 1'b0;
        tick();
        chk("ack_fall",   32'(ack[k]),  32'd0);
        chk("busy_fall",  32'(busy[k]), 32'd0);
        chk("rdata_hold", rdata[k],     last_rd[k]);
        chk("err_hold",   32'(err[k]),  32'(last_err[k]));
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic abort_store(input int k, input int addr, input logic [31:0] wd);
        we_s[k]   = 1'b1;
        addr_s[k] = 8'(addr);
        wd_s[k]   = wd;
        req[k]    = 1'b1;
        tick();
        tick();
        req[k] = 1'b0;
        tick();
        chk("abort_ack",   32'(ack[k]),  32'd0);
        chk("abort_busy",  32'(busy[k]), 32'd0);
        chk("abort_rdata", rdata[k],     last_rd[k]);
        chk("abort_err",   32'(err[k]),  32'(last_err[k]));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 8'h0; wd_s[k] = 32'h0;
            last_rd[k] = 32'h0; last_err[k] = 1'b0; ack_prev[k] = 1'b0;
            for (int a = 0; a < 256; a++) begin
                mem_m[k][a] = 32'h0;
                wr_m[k][a]  = 1'b0;
            end
        end
        rst_f = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack",   32'(ack[k]),  32'd0);
            chk("rst_busy",  32'(busy[k]), 32'd0);
            chk("rst_err",   32'(err[k]),  32'd0);
            chk("rst_rdata", rdata[k],     32'h0);
        end
        rst_f = 1'b1;
        tick();

        access(0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 8'h05, 32'h0, 1'b0);
        access(0, 1'b1, 8'h00, 32'hA5A5_0F0F, 1'b0);
        access(0, 1'b1, 8'h20, 32'h0000_1234, 1'b0);
        access(0, 1'b0, 8'h00, 32'h0, 1'b0);
        access(0, 1'b1, 8'h07, 32'h0000_0011, 1'b0);
        abort_store(0, 8'h07, 32'h0000_0055);
        access(0, 1'b0, 8'h07, 32'h0, 1'b0);
        access(0, 1'b0, 8'h05, 32'h0, 1'b1);

        // Reset in the middle of a store: outputs clear at once, store lost.
        we_s[0] = 1'b1; addr_s[0] = 8'h05; wd_s[0] = 32'h0BAD_F00D; req[0] = 1'b1;
        tick();
        rst_f = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_ack",   32'(ack[k]),  32'd0);
            chk("midrst_busy",  32'(busy[k]), 32'd0);
            chk("midrst_err",   32'(err[k]),  32'd0);
            chk("midrst_rdata", rdata[k],     32'h0);
            last_rd[k]  = 32'h0;
            last_err[k] = 1'b0;
        end
        req[0] = 1'b0;
        repeat (2) tick();
        rst_f = 1'b1;
        tick();
        access(0, 1'b0, 8'h05, 32'h0, 1'b0);

        access(1, 1'b0 | 1'b1, 8'h10, 32'h1357_9BDF, 1'b0);
        access(1, 1'b0, 8'h10, 32'h0, 1'b0);
        access(1, 1'b1, 8'h10, 32'h2468_ACE0, 1'b0);
        access(1, 1'b0, 8'h10, 32'h0, 1'b1);
        access(1, 1'b1, 8'hFF, 32'hFFFF_0001, 1'b0);
        access(1, 1'b0, 8'hFF, 32'h0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            int k;
            int a;
            bit w;
            k = $urandom_range(0, 1);
            a = (k == 0) ? $urandom_range(0, 31) : $urandom_range(0, 255);
            w = 1'($urandom_range(0, 1));
            if (!w && a < depth(k) && !wr_m[k][a]) w = 1'b1;
            access(k, w, a, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
